// File: rtl/sap_1_fetch_controller.sv
// rtl/sap_1_fetch_controller.sv - SAP-1 fetch/sequence controller with T1-T6 ring counter
module sap_1_fetch_controller #(
  parameter logic [3:0] PC_RESET   = 4'h0,
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input  logic       CLK,
  input  logic       CLRbar,
  input  logic [7:0] rom_data_in,
  output logic [3:0] mem_addr,
  output logic       CEbar,
  output logic [7:0] ir_out,
  output logic [3:0] pc_out,
  output logic [2:0] state_out,
  output logic       load_a,
  output logic       load_b,
  output logic       alu_sub,
  output logic       alu_en,
  output logic       acc_en,
  output logic       load_out,
  output logic       halted
);

  localparam logic [2:0] ST_T1   = 3'd0;
  localparam logic [2:0] ST_T2   = 3'd1;
  localparam logic [2:0] ST_T3   = 3'd2;
  localparam logic [2:0] ST_T4   = 3'd3;
  localparam logic [2:0] ST_T5   = 3'd4;
  localparam logic [2:0] ST_T6   = 3'd5;
  localparam logic [2:0] ST_HALT = 3'd6;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;

  logic [2:0] state;
  logic [3:0] pc;
  logic [3:0] mar;
  logic [7:0] ir;
  logic [3:0] opcode;
  logic       is_hlt;
  logic       is_mem_op;

  assign opcode    = ir[7:4];
  // HLT is checked first so a HLT_OPCODE override shadows any other decode
  assign is_hlt    = (opcode == HLT_OPCODE);
  assign is_mem_op = !is_hlt && (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB);

  always_ff @(posedge CLK or negedge CLRbar) begin
    if (!CLRbar) begin
      state <= ST_T1;
      pc    <= PC_RESET;
      mar   <= 4'h0;
      ir    <= 8'h00;
    end else begin
      case (state)
        ST_T1: begin
          mar   <= pc;
          state <= ST_T2;
        end
        ST_T2: begin
          pc    <= pc + 4'd1;
          state <= ST_T3;
        end
        ST_T3: begin
          ir    <= rom_data_in;
          state <= ST_T4;
        end
        ST_T4: begin
          if (is_hlt) begin
            state <= ST_HALT;
          end else begin
            if (is_mem_op) mar <= ir[3:0];
            state <= ST_T5;
          end
        end
        ST_T5:   state <= ST_T6;
        ST_T6:   state <= ST_T1;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_T1;
      endcase
    end
  end

  always_comb begin
    CEbar    = 1'b1;
    load_a   = 1'b0;
    load_b   = 1'b0;
    alu_sub  = 1'b0;
    alu_en   = 1'b0;
    acc_en   = 1'b0;
    load_out = 1'b0;
    case (state)
      ST_T3: CEbar = 1'b0;
      ST_T4: begin
        if (!is_hlt && opcode == OP_OUT) begin
          acc_en   = 1'b1;
          load_out = 1'b1;
        end
      end
      ST_T5: begin
        if (is_mem_op) begin
          CEbar  = 1'b0;
          load_a = (opcode == OP_LDA);
          load_b = (opcode != OP_LDA);
        end
      end
      ST_T6: begin
        if (is_mem_op && opcode != OP_LDA) begin
          alu_en  = 1'b1;
          load_a  = 1'b1;
          alu_sub = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign mem_addr  = mar;
  assign ir_out    = ir;
  assign pc_out    = pc;
  assign state_out = state;
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_sap_1_fetch_controller.sv
// tb/tb_sap_1_fetch_controller.sv - self-checking bench for sap_1_fetch_controller
module tb_sap_1_fetch_controller;

  logic       CLK = 1'b0;
  logic       CLRbar;
  logic [7:0] rom_data_in;
  logic [3:0] mem_addr;
  logic       CEbar;
  logic [7:0] ir_out;
  logic [3:0] pc_out;
  logic [2:0] state_out;
  logic       load_a, load_b, alu_sub, alu_en, acc_en, load_out, halted;

  sap_1_fetch_controller dut (
    .CLK(CLK), .CLRbar(CLRbar), .rom_data_in(rom_data_in), .mem_addr(mem_addr),
    .CEbar(CEbar), .ir_out(ir_out), .pc_out(pc_out), .state_out(state_out),
    .load_a(load_a), .load_b(load_b), .alu_sub(alu_sub), .alu_en(alu_en),
    .acc_en(acc_en), .load_out(load_out), .halted(halted)
  );

  always #5 CLK = ~CLK;

  logic [7:0] rom [16];
  logic [7:0] junk;
  int checks = 0;
  int errors = 0;

  // Bus floats to garbage whenever the ROM is not enabled
  always_comb rom_data_in = CEbar ? junk : rom[mem_addr];

  // Control word bits: {ce_active, load_a, load_b, alu_sub, alu_en, acc_en, load_out}
  logic [6:0] exec_tab [5][3];
  int         m_phase;
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir;
  logic       ce_log [$];
  logic       la_log [$];

  function automatic int op_class(input logic [3:0] op);
    case (op)
      4'h0: return 0;
      4'h1: return 1;
      4'h2: return 2;
      4'hE: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [6:0] exp_ctrl();
    if (m_phase == 6) return 7'b0;
    if (m_phase < 3) return (m_phase == 2) ? 7'b1000000 : 7'b0;
    return exec_tab[op_class(m_ir[7:4])][m_phase - 3];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = 4'h0; m_mar = 4'h0; m_ir = 8'h00;
    ce_log.delete(); la_log.delete();
  endtask

  task automatic model_step();
    if (m_phase == 6) return;
    case (m_phase)
      0: m_mar = m_pc;
      1: m_pc = 4'((m_pc + 1) % 16);
      2: m_ir = rom[m_mar];
      3: begin
        if (m_ir[7:4] == 4'hF) begin m_phase = 6; return; end
        if (m_ir[7:4] <= 4'h2) m_mar = m_ir[3:0];
      end
      default: ;
    endcase
    m_phase = (m_phase + 1) % 6;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(state_out), 32'(m_phase));
    chk("pc", 32'(pc_out), 32'(m_pc));
    chk("mem_addr", 32'(mem_addr), 32'(m_mar));
    chk("ir", 32'(ir_out), 32'(m_ir));
    chk("halted", 32'(halted), 32'(m_phase == 6));
    chk("ctrl", 32'({~CEbar, load_a, load_b, alu_sub, alu_en, acc_en, load_out}), 32'(exp_ctrl()));
  endtask

  task automatic do_reset();
    CLRbar = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLK);
    #2 CLRbar = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      compare_all();
      ce_log.push_back(~CEbar);
      la_log.push_back(load_a);
      junk = 8'($urandom);
      model_step();
      @(negedge CLK);
    end
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    logic [12:0] ce_exp, ce_got, la_exp, la_got;
    for (int c = 0; c < 5; c++)
      for (int p = 0; p < 3; p++) exec_tab[c][p] = 7'b0;
    exec_tab[0][1] = 7'b1100000;
    exec_tab[1][1] = 7'b1010000;
    exec_tab[1][2] = 7'b0100100;
    exec_tab[2][1] = 7'b1010000;
    exec_tab[2][2] = 7'b0101100;
    exec_tab[3][0] = 7'b0000011;
    junk = 8'hA5;

    // LDA 0xA everywhere
    fill_rom(8'h0A);
    do_reset();
    run(8);
    chk("lda_pc_after_c8", 32'(pc_out), 32'd2);
    run(4);
    ce_exp = '0; la_exp = '0;
    ce_exp[3] = 1; ce_exp[5] = 1; ce_exp[9] = 1; ce_exp[11] = 1;
    la_exp[5] = 1; la_exp[11] = 1;
    ce_got = '0; la_got = '0;
    for (int i = 0; i < 12; i++) begin
      ce_got[i + 1] = ce_log[i];
      la_got[i + 1] = la_log[i];
    end
    chk("lda_ce_cycles", 32'(ce_got), 32'(ce_exp));
    chk("lda_load_a_cycles", 32'(la_got), 32'(la_exp));

    // ADD C then SUB C
    for (int k = 0; k < 2; k++) begin
      fill_rom(8'h30);
      rom[0] = (k == 0) ? 8'h1C : 8'h2C;
      do_reset();
      run(3);
      chk("arith_ir", 32'(ir_out), 32'(rom[0]));
      run(1);
      chk("arith_t5_addr", 32'(mem_addr), 32'hC);
      chk("arith_t5_load_b", 32'({load_b, CEbar}), 32'b10);
      run(1);
      chk("arith_t6", 32'({alu_en, load_a, alu_sub}), 32'({2'b11, k == 1}));
      run(7);
    end

    // OUT then HLT
    fill_rom(8'h30);
    rom[0] = 8'hE0; rom[1] = 8'hF0;
    do_reset();
    run(3);
    chk("out_c4", 32'({acc_en, load_out}), 32'b11);
    run(7);
    chk("hlt_c11", 32'({halted, CEbar}), 32'b11);
    run(20);
    chk("hlt_pc_frozen", 32'(pc_out), 32'd2);

    // NOP run across PC wrap
    fill_rom(8'h30);
    do_reset();
    run(91);
    chk("wrap_pc_c92", 32'(pc_out), 32'd15);
    run(1);
    chk("wrap_pc_c93", 32'(pc_out), 32'd0);
    run(5);
    chk("wrap_mar_after_t1", 32'(mem_addr), 32'd0);

    // Random programs
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      do_reset();
      run(72);
    end

    // Asynchronous reset during T5 of an LDA
    fill_rom(8'h0A);
    do_reset();
    run(4);
    #2 CLRbar = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLK);
    #2 CLRbar = 1'b1;
    run(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_1_fetch_controller.md
Name: sap_1_fetch_controller

Overview:
SAP-1 fetch/sequence controller. It is the reader side of the 16x8 program ROM. It owns the program counter (PC), memory address register (MAR) and instruction register (IR), and runs the T1–T6 ring counter. It drives ROM address and active-low chip enable, captures instruction/operand bytes, and emits the per-state control word to the accumulator/ALU/output datapath.

Parameters:
PC_RESET, 4'h0, PC value loaded on reset
HLT_OPCODE, 4'hF, opcode that freezes the sequencer

Ports:
CLK  input  1  rising-edge clock
CLRbar  input  1  asynchronous active-low reset
rom_data_in  input  8  instruction/operand byte from ROM; valid only while CEbar=0
mem_addr  output  4  ROM address (MAR contents, registered)
CEbar  output  1  ROM chip enable, active-low
ir_out  output  8  IR contents
pc_out  output  4  PC contents
state_out  output  3  current state: 0..5 = T1..T6, 6 = HALT
load_a  output  1  accumulator load from memory or ALU
load_b  output  1  B register load from memory
alu_sub  output  1  ALU subtract select
alu_en  output  1  ALU result onto bus
acc_en  output  1  accumulator onto bus
load_out  output  1  output register load
halted  output  1  sequencer frozen

Behaviour:
- One clock domain; all state updates on CLK rising edge. Reset is asynchronous, active-low.
- Reset (CLRbar=0, effective immediately, mid-state included):
  - state=T1, PC=PC_RESET, MAR=0, IR=8'h00, halted=0.
  - CEbar=1; load_a, load_b, alu_sub, alu_en, acc_en, load_out = 0.
  - First T1 begins on the first rising edge after CLRbar deasserts.
- Ring counter: T1→T2→…→T6→T1, one state per cycle; 6-cycle instruction period.
- Control outputs and CEbar are combinational decodes of (state, IR[7:4]), stable for the whole state. Registers they name load at the rising edge that ends the state.
- Fetch (opcode-independent):
  - T1: MAR←PC at end of state.
  - T2: PC←PC+1 at end of state; 4-bit wrap, 15→0.
  - T3: CEbar=0; IR←rom_data_in at end of state.
- Execute, by opcode IR[7:4]:
  - LDA 4'h0: T4 MAR←IR[3:0]; T5 CEbar=0, load_a=1; T6 idle.
  - ADD 4'h1: T4 MAR←IR[3:0]; T5 CEbar=0, load_b=1; T6 alu_en=1, load_a=1.
  - SUB 4'h2: as ADD, with alu_sub=1 during T6 only.
  - OUT 4'hE: T4 acc_en=1, load_out=1; T5, T6 idle.
  - HLT_OPCODE: at the edge ending T4, state←HALT.
  - All other opcodes: T4–T6 idle (NOP), 6 cycles.
- HALT:
  - halted=1, CEbar=1, all controls 0.
  - PC, MAR and IR frozen.
  - Exit only via CLRbar.
- CEbar is never 0 outside T3, or outside T5 of LDA/ADD/SUB. CEbar=1 in all idle states.
- rom_data_in is ignored whenever CEbar=1 (may be Z/X); no register samples it.
- mem_addr always equals MAR; no combinational path from PC to mem_addr.
- Mutually exclusive per state: load_a with load_b; alu_en with acc_en.

Test Plan:
- Reset then 12 clocks, ROM all 8'h0A (LDA 0xA) -> CEbar=0 in cycles 3, 5, 9, 11 only; mem_addr=0, then A, then 1, then A; load_a high in cycles 5 and 11; pc_out=2 after cycle 8.
- ROM[0]=8'h1C (ADD C) -> IR=8'h1C after cycle 3; mem_addr=C during T5; load_b=1 in T5; alu_en=1 and load_a=1 with alu_sub=0 in T6.
- ROM[0]=8'h2C (SUB C) -> same sequence as ADD, with alu_sub=1 in T6 only.
- ROM[0]=8'hE0, ROM[1]=8'hF0 -> acc_en=1 and load_out=1 in cycle 4; halted=1 from cycle 11 on, CEbar=1; pc_out stays 2 for 20 further clocks.
- ROM all NOP 8'h30, run 96 clocks -> pc_out wraps 15→0 at the end of T2 of the 16th instruction; mem_addr=0 at the 17th T1.
- Assert CLRbar low mid-T5 of an LDA, between clock edges -> all outputs at reset values immediately, without a clock edge; after release the fetch restarts at PC_RESET.
